fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter: FIFO_DEPTH, default 2, number of instruction buffer entries; power of two, at least 2.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset is synchronous and active-high.
REQ-004 PC  input  32  current PC from PC_Module.
REQ-005 pc_advance  output  1  pulse; PC_Module loads PC+4 on next edge.
REQ-006 redirect  input  1  branch/jump flush; PC_Module loads the target on the same edge.
REQ-007 imem_req_valid  output  1  instruction-memory request valid.
REQ-008 imem_req_ready  input  1  memory accepts request.
REQ-009 imem_req_addr  output  32  word-aligned fetch address.
REQ-010 imem_rsp_valid  input  1  in-order response valid.
REQ-011 imem_rsp_data  input  32  fetched instruction.
REQ-012 id_valid  output  1  head entry holds an instruction for decode.
REQ-013 id_ready  input  1  decode consumes head.
REQ-014 id_instr  output  32  head instruction.
REQ-015 id_pc  output  32  PC of head instruction.
REQ-016 id_misalign  output  1  head entry is a misaligned-fetch marker.

Function
REQ-017 Credit rule: imem_req_valid = !redirect && !halt && (entries + outstanding < FIFO_DEPTH), using registered counts only.
REQ-018 imem_req_addr = {PC[31:2],2'b00} whenever imem_req_valid is 1.
REQ-019 On imem_req_valid && imem_req_ready: pc_advance=1 that cycle, an entry is allocated at tail with pc=PC and filled=0, outstanding+1.
REQ-020 pc_advance is 0 in every other cycle, including any redirect cycle.
REQ-021 Responses arrive at least 1 cycle after acceptance and in order; each fills the oldest unfilled entry, outstanding-1.
REQ-022 id_valid = head entry allocated and filled; id_instr, id_pc, id_misalign come from head registers (no combinational path from imem_rsp_*).
REQ-023 id_valid && id_ready pops head on that edge; a pop frees credit only from the next cycle.
REQ-024 Back-to-back throughput: one instruction per cycle sustained when memory latency is 1 and id_ready=1.
REQ-025 Redirect: all entries discarded, drop_cnt = outstanding count (including any request accepted that cycle is impossible per REQ-017); next cycle requests resume from the new PC.
REQ-026 While drop_cnt>0 each response is discarded and decrements drop_cnt; it fills no entry.
REQ-027 Redirect has priority over same-cycle response, pop and allocation; a same-cycle response counts toward drop_cnt.
REQ-028 Full buffer: no request issued; no overflow or underflow of entries, outstanding or drop_cnt under any input sequence.
REQ-029 Pointers wrap modulo FIFO_DEPTH.

Reset
REQ-030 While rst=1 on an edge: entries, outstanding, drop_cnt, pointers, halt cleared; next cycle id_valid=0, pc_advance=0, imem_req_valid=1 (credit available), id_instr=0, id_pc=0, id_misalign=0.
REQ-031 Reset mid-operation discards all entries and forgets outstanding requests; the memory side is reset concurrently.

Configuration
REQ-032 Macro FETCH_MISALIGN_CHECK_EN defined: if PC[1:0]!=0 when a request would issue, no memory request; an entry is allocated already filled with id_instr=32'h00000013, id_pc=PC, id_misalign=1; pc_advance=0; halt set until redirect or rst.
REQ-033 Macro undefined: PC[1:0] ignored, no halt state, id_misalign tied to 0.

Verification
REQ-034 Reset, PC=0x00000000, ready=1, latency 1 -> id_pc 0x0,0x4,0x8 on consecutive cycles, id_valid continuously 1.
REQ-035 id_ready=0 with FIFO_DEPTH=2 -> exactly 2 requests accepted, imem_req_valid=0 thereafter, no further pc_advance.
REQ-036 Two outstanding (0x10,0x14), redirect to 0x100 -> both responses dropped, first id_pc=0x100.
REQ-037 Redirect same cycle as response for 0x20 -> response dropped, id_valid=0 next cycle.
REQ-038 rst asserted with 2 entries and 1 outstanding -> next cycle id_valid=0, imem_req_valid=1.
REQ-039 With FETCH_MISALIGN_CHECK_EN, PC=0x00000006 -> no memory request, id_instr=0x00000013, id_misalign=1, pc_advance stays 0 until redirect.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch front end: credit-limited requests to instruction memory, in-order
// response buffer toward decode, redirect flush with in-flight response dropping.
// Optional misaligned-PC trap buffer entry enabled by defining FETCH_MISALIGN_CHECK_EN.
module fetch_unit #(
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] PC,
    output logic        pc_advance,
    input  logic        redirect,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic        id_misalign
);
    localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = PW + 1;
    localparam int unsigned SW = CW + 1;
    localparam int unsigned DW = PW + 3;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    logic [PW-1:0]         head_q, head_d, tail_q, tail_d, fill_idx;
    logic [CW-1:0]         ent_q, ent_d, out_q, out_d;
    logic [DW-1:0]         drop_q, drop_d;
    logic [FIFO_DEPTH-1:0] filled_q;
    logic [31:0]           instr_q [FIFO_DEPTH];
    logic [31:0]           pc_q    [FIFO_DEPTH];
    logic                  halt, misal, credit, issue, alloc, rsp_live, rsp_any, pop;

`ifdef FETCH_MISALIGN_CHECK_EN
    logic                  halt_q, halt_d;
    logic [FIFO_DEPTH-1:0] mis_q;
    assign halt        = halt_q;
    assign misal       = (PC[1:0] != 2'b00);
    assign id_misalign = mis_q[head_q];
`else
    assign halt        = 1'b0;
    assign misal       = 1'b0;
    assign id_misalign = 1'b0;
`endif

    // Request side: credit counts filled entries plus requests still in flight.
    assign credit         = (SW'(ent_q) + SW'(out_q)) < SW'(FIFO_DEPTH);
    assign issue          = !redirect && !halt && credit;
    assign imem_req_valid = issue && !misal;
    assign imem_req_addr  = {PC[31:2], 2'b00};
    assign pc_advance     = imem_req_valid && imem_req_ready;
    assign alloc          = issue && (misal || imem_req_ready);

    // Unfilled entries sit just behind the tail; a trap entry (only ever last) is skipped.
    assign fill_idx = tail_q - PW'(out_q) - PW'(halt);
    assign rsp_any  = imem_rsp_valid && ((drop_q != '0) || (out_q != '0));
    assign rsp_live = imem_rsp_valid && (drop_q == '0) && (out_q != '0);

    assign id_valid = filled_q[head_q];
    assign id_instr = instr_q[head_q];
    assign id_pc    = pc_q[head_q];
    assign pop      = id_valid && id_ready;

    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        ent_d  = ent_q;
        out_d  = out_q;
        drop_d = drop_q;
        if (redirect) begin
            head_d = '0;
            tail_d = '0;
            ent_d  = '0;
            out_d  = '0;
            drop_d = drop_q + DW'(out_q) - DW'(rsp_any);
        end else begin
            head_d = head_q + PW'(pop);
            tail_d = tail_q + PW'(alloc);
            ent_d  = ent_q + CW'(rsp_live) + CW'(issue && misal) - CW'(pop);
            out_d  = out_q + CW'(pc_advance) - CW'(rsp_live);
            if (imem_rsp_valid && (drop_q != '0)) begin
                drop_d = drop_q - DW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q   <= '0;
            tail_q   <= '0;
            ent_q    <= '0;
            out_q    <= '0;
            drop_q   <= '0;
            filled_q <= '0;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                instr_q[i] <= '0;
                pc_q[i]    <= '0;
            end
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            ent_q  <= ent_d;
            out_q  <= out_d;
            drop_q <= drop_d;
            if (redirect) begin
                filled_q <= '0;
            end else begin
                if (rsp_live) begin
                    filled_q[fill_idx] <= 1'b1;
                    instr_q[fill_idx]  <= imem_rsp_data;
                end
                if (pop) begin
                    filled_q[head_q] <= 1'b0;
                end
                if (alloc) begin
                    pc_q[tail_q]     <= PC;
                    filled_q[tail_q] <= misal;
                    if (misal) begin
                        instr_q[tail_q] <= NOP_INSTR;
                    end
                end
            end
        end
    end

`ifdef FETCH_MISALIGN_CHECK_EN
    always_comb begin
        halt_d = halt_q;
        if (redirect) begin
            halt_d = 1'b0;
        end else if (issue && misal) begin
            halt_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            halt_q <= 1'b0;
            mis_q  <= '0;
        end else begin
            halt_q <= halt_d;
            if (!redirect && alloc) begin
                mis_q[tail_q] <= misal;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: queue-based reference model of the fetch buffer, in-order
// memory and PC register models, directed scenarios and randomized traffic.
module tb_fetch_unit;
    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst, redirect, pc_advance, imem_req_valid, imem_req_ready;
    logic        imem_rsp_valid, id_valid, id_ready, id_misalign;
    logic [31:0] PC, imem_req_addr, imem_rsp_data, id_instr, id_pc;

    always #5 clk = ~clk;

    fetch_unit #(.FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .PC(PC), .pc_advance(pc_advance), .redirect(redirect),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data), .id_valid(id_valid), .id_ready(id_ready),
        .id_instr(id_instr), .id_pc(id_pc), .id_misalign(id_misalign)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        mis;
        logic        filled;
    } ent_t;

    typedef struct packed {
        int          due;
        logic [31:0] data;
    } mrsp_t;

    ent_t        mdl[$];
    mrsp_t       mq[$];
    int          m_drop = 0;
    bit          m_halt = 0;
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          lat_min = 1;
    int          lat_max = 1;
    bit          rst_v, redir_v, rdy_v, idr_v, hold_v;
    logic [31:0] tgt_v, rst_pc, pc_nxt;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'hC3A5, ~a[15:0]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d got=%h want=%h", name, cyc, act, exp);
        end
    endtask

    // Compare DUT outputs with the model, then advance the model across the coming edge.
    task automatic model_cycle();
        logic misal, issue, e_rv, e_adv, hv;
        int   unf;
        ent_t e;
        misal = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
        misal = (PC[1:0] != 2'b00);
`endif
        issue = !redirect && !m_halt && (mdl.size() < int'(DEPTH));
        e_rv  = issue && !misal;
        e_adv = e_rv && imem_req_ready;
        hv    = 1'b0;
        if (mdl.size() > 0) hv = mdl[0].filled;
        chk("req_valid", imem_req_valid, e_rv);
        chk("pc_advance", pc_advance, e_adv);
        if (e_rv) chk("req_addr", imem_req_addr, {PC[31:2], 2'b00});
        chk("id_valid", id_valid, hv);
        if (hv) begin
            chk("id_pc", id_pc, mdl[0].pc);
            chk("id_instr", id_instr, mdl[0].instr);
            chk("id_misalign", id_misalign, mdl[0].mis);
        end
        if (rst) begin
            mdl.delete();
            m_drop = 0;
            m_halt = 0;
        end else if (redirect) begin
            unf = 0;
            foreach (mdl[i]) if (!mdl[i].filled) unf++;
            m_drop = m_drop + unf - (imem_rsp_valid ? 1 : 0);
            if (m_drop < 0) m_drop = 0;
            mdl.delete();
            m_halt = 0;
        end else begin
            if (imem_rsp_valid) begin
                if (m_drop > 0) m_drop--;
                else begin
                    for (int i = 0; i < mdl.size(); i++) begin
                        if (!mdl[i].filled) begin
                            e = mdl[i];
                            e.filled = 1'b1;
                            e.instr = imem_rsp_data;
                            mdl[i] = e;
                            break;
                        end
                    end
                end
            end
            if (hv && id_ready) void'(mdl.pop_front());
            if (issue) begin
                if (misal) begin
                    mdl.push_back('{pc: PC, instr: 32'h0000_0013, mis: 1'b1, filled: 1'b1});
                    m_halt = 1;
                end else if (imem_req_ready) begin
                    mdl.push_back('{pc: PC, instr: 32'h0, mis: 1'b0, filled: 1'b0});
                end
            end
        end
    endtask

    // Memory and PC register react to what the DUT actually does.
    task automatic env_step();
        if (rst) mq.delete();
        else begin
            if (imem_rsp_valid) void'(mq.pop_front());
            if (imem_req_valid && imem_req_ready)
                mq.push_back('{due: cyc + $urandom_range(lat_min, lat_max), data: mem_word(imem_req_addr)});
        end
        pc_nxt = rst ? rst_pc : redirect ? tgt_v : pc_advance ? PC + 32'd4 : PC;
    endtask

    task automatic cycle();
        @(negedge clk);
        PC             = pc_nxt;
        rst            = rst_v;
        redirect       = redir_v;
        imem_req_ready = rdy_v;
        id_ready       = idr_v;
        if (!rst_v && !hold_v && mq.size() > 0 && mq[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mq[0].data;
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
        end
        #1;
        model_cycle();
        env_step();
        cyc++;
    endtask

    task automatic do_reset(input logic [31:0] pc0);
        rst_v = 1; rst_pc = pc0; redir_v = 0; rdy_v = 0; idr_v = 0; hold_v = 0;
        cycle();
        rst_v = 0;
    endtask

    task automatic wait_first_valid(input int budget, output bit f, output logic [31:0] p);
        f = 0;
        p = '0;
        for (int i = 0; i < budget && !f; i++) begin
            cycle();
            if (id_valid) begin
                f = 1;
                p = id_pc;
            end
        end
    endtask

    bit          tv[8];
    logic [31:0] tp[8];
    int          acc;
    bit          found;
    logic [31:0] fpc;

    initial begin
        rst = 1; redirect = 0; imem_req_ready = 0; imem_rsp_valid = 0; id_ready = 0;
        PC = '0; imem_rsp_data = '0; pc_nxt = '0; tgt_v = '0; rst_pc = '0;
        rst_v = 1; redir_v = 0; rdy_v = 0; idr_v = 0; hold_v = 0;

        // Reset state
        do_reset(32'h0);
        cycle();
        chk("rst_id_valid", id_valid, 0);
        chk("rst_req_valid", imem_req_valid, 1);
        chk("rst_pc_advance", pc_advance, 0);
        chk("rst_id_instr", id_instr, 0);
        chk("rst_id_pc", id_pc, 0);
        chk("rst_id_misalign", id_misalign, 0);

        // Sustained throughput with latency 1
        rdy_v = 1; idr_v = 1; lat_min = 1; lat_max = 1;
        for (int i = 0; i < 6; i++) begin
            cycle();
            tv[i] = id_valid;
            tp[i] = id_pc;
        end
        chk("tput_v1", tv[1], 0);
        chk("tput_v2", tv[2], 1);
        chk("tput_v3", tv[3], 1);
        chk("tput_v4", tv[4], 1);
        chk("tput_v5", tv[5], 1);
        chk("tput_pc2", tp[2], 32'h0);
        chk("tput_pc3", tp[3], 32'h4);
        chk("tput_pc4", tp[4], 32'h8);
        chk("tput_pc5", tp[5], 32'hC);

        // Decode stalled: buffer fills, requests stop
        do_reset(32'h40);
        rdy_v = 1; idr_v = 0;
        acc = 0;
        for (int i = 0; i < 12; i++) begin
            cycle();
            acc += int'(pc_advance);
        end
        chk("stall_accepts", acc, DEPTH);
        chk("stall_req_valid", imem_req_valid, 0);
        chk("stall_pc_advance", pc_advance, 0);
        chk("stall_head_pc", id_pc, 32'h40);

        // Redirect with two requests in flight
        do_reset(32'h10);
        rdy_v = 1; idr_v = 1; hold_v = 1;
        acc = 0;
        cycle(); acc += int'(pc_advance);
        cycle(); acc += int'(pc_advance);
        chk("redir_inflight", acc, 2);
        rdy_v = 0; redir_v = 1; tgt_v = 32'h100;
        cycle();
        redir_v = 0; rdy_v = 1; hold_v = 0;
        wait_first_valid(20, found, fpc);
        chk("redir_found", found, 1);
        chk("redir_first_pc", fpc, 32'h100);

        // Redirect in the same cycle as a response
        do_reset(32'h20);
        rdy_v = 1; idr_v = 1;
        cycle();
        rdy_v = 0; redir_v = 1; tgt_v = 32'h200;
        cycle();
        redir_v = 0;
        cycle();
        chk("redir_rsp_id_valid", id_valid, 0);
        rdy_v = 1;
        wait_first_valid(20, found, fpc);
        chk("redir_rsp_found", found, 1);
        chk("redir_rsp_first_pc", fpc, 32'h200);
        chk("redir_rsp_instr", id_instr, mem_word(32'h200));

        // Reset with two entries and one request in flight
        do_reset(32'h80);
        rdy_v = 1; idr_v = 0;
        repeat (3) cycle();
        rst_v = 1; rdy_v = 0; hold_v = 1;
        cycle();
        chk("pre_rst_id_valid", id_valid, 1);
        chk("pre_rst_id_pc", id_pc, 32'h80);
        rst_v = 0; hold_v = 0;
        cycle();
        chk("mid_rst_id_valid", id_valid, 0);
        chk("mid_rst_req_valid", imem_req_valid, 1);

        // Misaligned PC
        do_reset(32'h6);
        rdy_v = 1; idr_v = 0;
        cycle();
`ifdef FETCH_MISALIGN_CHECK_EN
        chk("mis_req_valid", imem_req_valid, 0);
        chk("mis_pc_advance", pc_advance, 0);
        cycle();
        chk("mis_id_valid", id_valid, 1);
        chk("mis_id_instr", id_instr, 32'h0000_0013);
        chk("mis_id_misalign", id_misalign, 1);
        chk("mis_id_pc", id_pc, 32'h6);
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("mis_halt_adv", pc_advance, 0);
        end
        redir_v = 1; tgt_v = 32'h300; idr_v = 1;
        cycle();
        redir_v = 0;
        wait_first_valid(20, found, fpc);
        chk("mis_recover_pc", fpc, 32'h300);
`else
        chk("mis_off_addr", imem_req_addr, 32'h4);
        chk("mis_off_adv", pc_advance, 1);
        cycle();
        cycle();
        chk("mis_off_id_valid", id_valid, 1);
        chk("mis_off_id_pc", id_pc, 32'h6);
        chk("mis_off_id_misalign", id_misalign, 0);
`endif

        // Randomized traffic
        do_reset(32'h1000);
        lat_min = 1; lat_max = 3;
        for (int i = 0; i < 3000; i++) begin
            rdy_v   = ($urandom_range(0, 3) != 0);
            idr_v   = ($urandom_range(0, 3) != 0);
            hold_v  = ($urandom_range(0, 4) == 0);
            redir_v = ($urandom_range(0, 29) == 0);
            rst_v   = ($urandom_range(0, 299) == 0);
            tgt_v   = ($urandom & 32'h0000_FFFC)
                    | (($urandom_range(0, 9) == 0) ? 32'($urandom_range(1, 3)) : 32'h0);
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
